// File: rtl/proj_kmer_buffer_if.sv
// Symbol stream into the k-mer window and the parallel window back out to the hash stage.
interface proj_kmer_buffer_if #(
    parameter int DATA_BITS = 2,
    parameter int KMER_LEN  = 16
);
    logic [DATA_BITS-1:0]               in_data;
    logic                               start_over;
    logic [KMER_LEN-1:0][DATA_BITS-1:0] out_kmer;
    logic                               full;

    modport master (
        output in_data,
        output start_over,
        input  out_kmer,
        input  full
    );

    modport slave (
        input  in_data,
        input  start_over,
        output out_kmer,
        output full
    );
endinterface

// File: rtl/proj_kmer_buffer.sv
// Sliding-window k-mer assembler; index 0 of out_kmer is the newest symbol.
// Optional macro PROJ_KMER_BUFFER_CLEAR_EN: start_over also zeroes the window contents.
module proj_kmer_buffer #(
    parameter int DATA_BITS = 2,
    parameter int KMER_LEN  = 16,
    parameter int OUT_KMER  = KMER_LEN * DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    proj_kmer_buffer_if.slave    bus
);
    localparam int CNT_W = $clog2(KMER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(KMER_LEN);

    generate
        if (OUT_KMER != KMER_LEN * DATA_BITS) begin : g_bad_width
            $error("proj_kmer_buffer: OUT_KMER must equal KMER_LEN*DATA_BITS");
        end
        if (KMER_LEN < 2) begin : g_bad_len
            $error("proj_kmer_buffer: KMER_LEN must be at least 2");
        end
    endgenerate

    logic [KMER_LEN-1:0][DATA_BITS-1:0] window_q, window_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;

    // start_over discards the current symbol; the fill count saturates so full never drops on its own.
    always_comb begin
        window_d = window_q;
        cnt_d    = cnt_q;
        if (bus.start_over) begin
            cnt_d = '0;
`ifdef PROJ_KMER_BUFFER_CLEAR_EN
            window_d = '0;
`else
            window_d = window_q;
`endif
        end else begin
            window_d = {window_q[KMER_LEN-2:0], bus.in_data};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
            cnt_q    <= '0;
        end else begin
            window_q <= window_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.out_kmer = window_q;
    assign bus.full     = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_proj_kmer_buffer.sv
// Directed bench for proj_kmer_buffer; expected windows are queued at drive time and popped after each edge.
module tb_proj_kmer_buffer;
    localparam int DB = 2;
    localparam int KL = 16;

    typedef struct {
        logic [31:0] win;
        logic        full;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [31:0] m_win;
    int          m_cnt;
    logic [31:0] saved_win;
    int          rise_edge;

    proj_kmer_buffer_if #(.DATA_BITS(DB), .KMER_LEN(KL)) bus ();

    proj_kmer_buffer #(.DATA_BITS(DB), .KMER_LEN(KL), .OUT_KMER(KL*DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of the window as a history of accepted symbols, newest in the low bits.
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] d);
        exp_t e;
        rst            = r;
        bus.start_over = s;
        bus.in_data    = d;
        if (r) begin
            m_win = '0;
            m_cnt = 0;
        end else if (s) begin
            m_cnt = 0;
`ifdef PROJ_KMER_BUFFER_CLEAR_EN
            m_win = '0;
`endif
        end else begin
            m_win = {m_win[29:0], d};
            if (m_cnt < KL) m_cnt++;
        end
        e.win  = m_win;
        e.full = (m_cnt == KL);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            checkValue("sb_window", 32'(bus.out_kmer), e.win);
            checkValue("sb_full", 32'(bus.full), 32'(e.full));
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [1:0] d);
        applyStimulus(r, s, d);
        checkOutput();
    endtask

    initial begin
        m_win = '0;
        m_cnt = 0;
        rst = 1'b1;
        bus.start_over = 1'b0;
        bus.in_data = 2'd3;

        // Reset held two cycles with in_data=3, then first shift
        step(1'b1, 1'b0, 2'd3);
        step(1'b1, 1'b0, 2'd3);
        checkValue("reset_window", 32'(bus.out_kmer), 32'h0);
        checkValue("reset_full", 32'(bus.full), 32'h0);
        step(1'b0, 1'b0, 2'd3);
        checkValue("first_shift", 32'(bus.out_kmer[0]), 32'd3);

        // Fill from a fresh reset with 0,1,2,3,...
        step(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < KL; i++) begin
            step(1'b0, 1'b0, 2'(i % 4));
            if (i == KL - 2) checkValue("fill_full_edge15", 32'(bus.full), 32'h0);
        end
        checkValue("fill_full_edge16", 32'(bus.full), 32'h1);
        checkValue("fill_oldest", 32'(bus.out_kmer[KL-1]), 32'd0);
        checkValue("fill_newest", 32'(bus.out_kmer[0]), 32'd3);

        // Slide with random symbols
        for (int i = 0; i < KL; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
        end
        checkValue("slide_full", 32'(bus.full), 32'h1);

        // Start over while full; in_data=2 must be discarded
        saved_win = 32'(bus.out_kmer);
        step(1'b0, 1'b1, 2'd2);
        checkValue("so_full", 32'(bus.full), 32'h0);
`ifdef PROJ_KMER_BUFFER_CLEAR_EN
        checkValue("so_window", 32'(bus.out_kmer), 32'h0);
`else
        checkValue("so_window", 32'(bus.out_kmer), saved_win);
`endif
        rise_edge = 0;
        for (int i = 0; i < KL; i++) begin
            step(1'b0, 1'b0, 2'((i + 1) % 4));
            if (bus.full && rise_edge == 0) rise_edge = i + 1;
        end
        checkValue("refill_edges", 32'(rise_edge), 32'd16);

        // rst and start_over together while full
        step(1'b1, 1'b1, 2'd1);
        checkValue("prio_window", 32'(bus.out_kmer), 32'h0);
        checkValue("prio_full", 32'(bus.full), 32'h0);

        // start_over on the cycle the 16th symbol would arrive
        for (int i = 0; i < KL - 1; i++) step(1'b0, 1'b0, 2'(i % 4));
        step(1'b0, 1'b1, 2'd3);
        checkValue("so_at_16_full", 32'(bus.full), 32'h0);
        step(1'b0, 1'b0, 2'd1);
        checkValue("so_at_16_next", 32'(bus.full), 32'h0);

        // Mid-fill reset after seven symbols, then a complete refill
        step(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'(3 - (i % 4)));
        step(1'b1, 1'b0, 2'd2);
        checkValue("midfill_window", 32'(bus.out_kmer), 32'h0);
        checkValue("midfill_full", 32'(bus.full), 32'h0);
        rise_edge = 0;
        for (int i = 0; i < KL; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            if (bus.full && rise_edge == 0) rise_edge = i + 1;
        end
        checkValue("midfill_refill_edges", 32'(rise_edge), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
